// File: rtl/sort_pkt_pkg.sv
// Shared definitions for the PC->FPGA sort packet receiver.
//   SYNC_BYTE : frame start marker
//   err_e     : error code reported on err_code_o
//   state_e   : parser states (also mirrored as localparams in sort_pkt_rx)
package sort_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_LEN,
        ERR_CSUM,
        ERR_TIMEOUT
    } err_e;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        DATA,
        CSUM
    } state_e;

endpackage

// File: rtl/sort_pkt_rx_if.sv
// Bundle of the sort_pkt_rx byte-input and element-output handshakes.
//   master : byte source / element sink (uart side + sorter side, or a testbench)
//   slave  : the packet parser
// Signals:
//   in_data_i/in_valid_i/in_ready_o          byte stream in
//   elem_data_o/elem_valid_o/elem_ready_i    element stream out
//   elem_last_o                              final element of a validated packet
//   pkt_done_o/pkt_err_o                     packet completion / abort pulses
//   err_code_o                               sticky err_e of the most recent error
interface sort_pkt_rx_if #(
    parameter int unsigned ELEM_W = 16
);
    logic [7:0]        in_data_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [ELEM_W-1:0] elem_data_o;
    logic              elem_valid_o;
    logic              elem_ready_i;
    logic              elem_last_o;
    logic              pkt_done_o;
    logic              pkt_err_o;
    logic [1:0]        err_code_o;

    modport master (
        output in_data_i, in_valid_i, elem_ready_i,
        input  in_ready_o, elem_data_o, elem_valid_o, elem_last_o,
        input  pkt_done_o, pkt_err_o, err_code_o
    );

    modport slave (
        input  in_data_i, in_valid_i, elem_ready_i,
        output in_ready_o, elem_data_o, elem_valid_o, elem_last_o,
        output pkt_done_o, pkt_err_o, err_code_o
    );
endinterface

// File: rtl/elem_packer.sv
// Byte-to-element packer: shifts bytes in big-endian order and strobes `pack`
// on the byte that completes an element. `word` is the element including the
// byte currently being shifted, so it is valid in the same cycle as `pack`.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   clear     drop any partially packed element
//   shift     accept byte_in this cycle
//   byte_in   incoming byte
//   word      packed element (first byte in the MSBs)
//   pack      this shift completes an element
module elem_packer #(
    parameter int unsigned ELEM_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    shift,
    input  logic [7:0]              byte_in,
    output logic [8*ELEM_BYTES-1:0] word,
    output logic                    pack
);
    localparam int unsigned ELEM_W = 8 * ELEM_BYTES;
    localparam int unsigned CW     = (ELEM_BYTES > 1) ? $clog2(ELEM_BYTES) : 1;

    logic [ELEM_W-1:0] sh_q;
    logic [CW-1:0]     cnt_q;

    // Truncating the concat keeps the newest ELEM_BYTES bytes.
    assign word = ELEM_W'({sh_q, byte_in});
    assign pack = shift && (cnt_q == CW'(ELEM_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (shift) begin
            sh_q  <= word;
            cnt_q <= pack ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/sort_pkt_rx.sv
// Packet parser for the PC->FPGA byte stream feeding the sorter.
// Frame: SYNC(A5), LEN=N, N*ELEM_BYTES data bytes, [CSUM = XOR of LEN and data].
// Elements leave as a valid/ready stream, last element flagged with elem_last_o.
// Optional feature: define SORT_PKT_CHECKSUM_EN to expect and verify the CSUM
// byte; the final element is then held back until the checksum matches.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       sort_pkt_rx_if.slave (byte input, element output, status pulses)
module sort_pkt_rx
    import sort_pkt_pkg::*;
#(
    parameter int unsigned ELEM_BYTES     = 2,
    parameter int unsigned MAX_ELEMS      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         rst,
    sort_pkt_rx_if.slave bus
);
    localparam int unsigned ELEM_W = 8 * ELEM_BYTES;
    localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LEN  = LEN;
    localparam logic [1:0] ST_DATA = DATA;
`ifdef SORT_PKT_CHECKSUM_EN
    localparam logic [1:0] ST_CSUM = CSUM;
`endif

    logic [1:0]        state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;       // elements packed so far
    logic [ELEM_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    err_e              code_q, code_d;
    logic [TW-1:0]     tmo_q, tmo_d;
`ifdef SORT_PKT_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              held_q, held_d;     // last element parked in data_q awaiting CSUM
`endif

    logic              in_ready;
    logic              accept;
    logic              hs;
    logic              tmo_run;
    logic              tmo_hit;
    logic [ELEM_W-1:0] pk_word;
    logic              pk_pack;

    // In DATA a byte may complete an element, so the output register must be
    // free (or freeing this cycle) before the byte is taken.
    assign in_ready = (state_q == ST_DATA) ? (!valid_q || bus.elem_ready_i) : 1'b1;
    assign accept   = bus.in_valid_i && in_ready;
    assign hs       = valid_q && bus.elem_ready_i;
    assign tmo_run  = (state_q != ST_IDLE) && in_ready && !bus.in_valid_i;
    assign tmo_hit  = tmo_run && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    elem_packer #(
        .ELEM_BYTES (ELEM_BYTES)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != ST_DATA),
        .shift   (accept && (state_q == ST_DATA)),
        .byte_in (bus.in_data_i),
        .word    (pk_word),
        .pack    (pk_pack)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        tmo_d   = tmo_q;
`ifdef SORT_PKT_CHECKSUM_EN
        csum_d  = csum_q;
        held_d  = held_q;
`endif

        if (hs) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (last_q) begin
                done_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept && (bus.in_data_i == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    len_d = bus.in_data_i;
                    cnt_d = '0;
`ifdef SORT_PKT_CHECKSUM_EN
                    csum_d = bus.in_data_i;
`endif
                    if (bus.in_data_i == 8'd0) begin
`ifdef SORT_PKT_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
`endif
                    end else if (bus.in_data_i > 8'(MAX_ELEMS)) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
`ifdef SORT_PKT_CHECKSUM_EN
                    csum_d = csum_q ^ bus.in_data_i;
`endif
                    if (pk_pack) begin
                        data_d = pk_word;
                        cnt_d  = cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == len_q) begin
`ifdef SORT_PKT_CHECKSUM_EN
                            held_d  = 1'b1;
                            state_d = ST_CSUM;
`else
                            valid_d = 1'b1;
                            last_d  = 1'b1;
                            state_d = ST_IDLE;
`endif
                        end else begin
                            valid_d = 1'b1;
                        end
                    end
                end
            end
`ifdef SORT_PKT_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    state_d = ST_IDLE;
                    held_d  = 1'b0;
                    if (bus.in_data_i == csum_q) begin
                        if (held_q) begin
                            valid_d = 1'b1;
                            last_d  = 1'b1;
                        end else begin
                            done_d = 1'b1;     // zero-length packet
                        end
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CSUM;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Idle-gap counter: only counts while waiting on the byte source.
        if (accept || (state_q == ST_IDLE)) begin
            tmo_d = '0;
        end else if (tmo_run && (tmo_q != TW'(TIMEOUT_CYCLES))) begin
            tmo_d = tmo_q + 1'b1;
        end

        // A presented element is kept; only a parked one is dropped.
        if (tmo_hit) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            tmo_d   = '0;
`ifdef SORT_PKT_CHECKSUM_EN
            held_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            tmo_q   <= '0;
`ifdef SORT_PKT_CHECKSUM_EN
            csum_q  <= '0;
            held_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            tmo_q   <= tmo_d;
`ifdef SORT_PKT_CHECKSUM_EN
            csum_q  <= csum_d;
            held_q  <= held_d;
`endif
        end
    end

    assign bus.in_ready_o   = in_ready;
    assign bus.elem_data_o  = data_q;
    assign bus.elem_valid_o = valid_q;
    assign bus.elem_last_o  = last_q;
    assign bus.pkt_done_o   = done_q;
    assign bus.pkt_err_o    = err_q;
    assign bus.err_code_o   = code_q;
endmodule
